// File: rtl/logic_74xx161_param_pkg.sv
// Shared constants for the parametrised logic IP models.
package logic_74xx161_param_pkg;

   // Active level of the logic-level clock that counts as an edge
   localparam bit EDGE_FALL = 1'b0;
   localparam bit EDGE_RISE = 1'b1;

   // Clear behaviour: act on every FAST_CLK, or only on a qualified edge
   localparam bit CLR_ASYNC     = 1'b0;
   localparam bit CLR_SYNC_EDGE = 1'b1;

endpackage

// File: rtl/logic_edge_det.sv
// Edge detector for a logic-level clock sampled on FAST_CLK.
module logic_edge_det
   import logic_74xx161_param_pkg::*;
#(
   parameter bit EDGE = EDGE_RISE
) (
   input  logic FAST_CLK,
   input  logic RST,
   input  logic I_CLK,
   output logic O_EDGE,
   output logic O_EDGE_C
);

   logic clk_q;

   // Qualified edge as seen by the sampling FAST_CLK posedge
   assign O_EDGE_C = (clk_q != I_CLK) & (I_CLK == EDGE);

   // Previous I_CLK level resets to the active level so release never strobes
   always_ff @(posedge FAST_CLK or negedge RST) begin
      if (!RST) begin
         clk_q  <= EDGE;
         O_EDGE <= 1'b0;
      end else begin
         clk_q  <= I_CLK;
         O_EDGE <= O_EDGE_C;
      end
   end

endmodule

// File: rtl/logic_74xx161_param.sv
// Cascadable presettable binary counter generalising the 74xx161/163/191.
module logic_74xx161_param
   import logic_74xx161_param_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MAX      = (2 ** WIDTH) - 1,
   parameter bit          CLR_SYNC = CLR_ASYNC,
   parameter bit          EDGE     = EDGE_RISE,
   parameter bit          UPDN     = 1'b0
) (
   input  logic             FAST_CLK,
   input  logic             RST,
   input  logic             I_CLK,
   input  logic             I_CLR_N,
   input  logic             I_LD_N,
   input  logic             I_ENP,
   input  logic             I_ENT,
   input  logic             I_UP,
   input  logic [WIDTH-1:0] I_D,
   output logic [WIDTH-1:0] O_Q,
   output logic             O_RCO,
   output logic             O_EDGE
);

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ZERO_V = '0;
   localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

   logic             act_edge_c;
   logic             dir_up_c;
   logic [WIDTH-1:0] q_nxt_c;

   // Edge detection on the logic-level counter clock
   logic_edge_det #(
      .EDGE (EDGE)
   ) u_edge_det (
      .FAST_CLK (FAST_CLK),
      .RST      (RST),
      .I_CLK    (I_CLK),
      .O_EDGE   (O_EDGE),
      .O_EDGE_C (act_edge_c)
   );

   // Direction is fixed up unless the up/down option is built in
   assign dir_up_c = (UPDN == 1'b0) ? 1'b1 : I_UP;

   // Carry out looks at the terminal value for the current direction
   assign O_RCO = I_ENT & (O_Q == (dir_up_c ? MAX_V : ZERO_V));

   // Next counter value: clear, then load, then count, else hold
   always_comb begin
      q_nxt_c = O_Q;
      if ((CLR_SYNC == CLR_ASYNC) && !I_CLR_N) begin
         q_nxt_c = ZERO_V;
      end else if (act_edge_c) begin
         if ((CLR_SYNC == CLR_SYNC_EDGE) && !I_CLR_N) begin
            q_nxt_c = ZERO_V;
         end else if (!I_LD_N) begin
            q_nxt_c = I_D;
         end else if (I_ENP && I_ENT) begin
            if (dir_up_c) begin
               q_nxt_c = (O_Q == MAX_V) ? ZERO_V : O_Q + ONE_V;
            end else begin
               q_nxt_c = (O_Q == ZERO_V) ? MAX_V : O_Q - ONE_V;
            end
         end
      end
   end

   // Counter register
   always_ff @(posedge FAST_CLK or negedge RST) begin
      if (!RST) begin
         O_Q <= ZERO_V;
      end else begin
         O_Q <= q_nxt_c;
      end
   end

endmodule

// File: tb/tb_logic_74xx161_param.sv
// Directed self-checking bench for logic_74xx161_param.
module tb_logic_74xx161_param;

   logic       fast_clk = 1'b0;
   logic       rst_n;
   logic [2:0] iclk;

   // group a: 4-bit mod-16 async clear (u_a rising, u_f falling)
   logic       clr_a_n, ld_a_n, enp_a, ent_a;
   logic [3:0] d_a, q_a, q_f;
   logic       rco_a, rco_f, e_a, e_f;

   // group b: 4-bit mod-10 up/down with edge-qualified clear
   logic       clr_b_n, ld_b_n, enp_b, ent_b, up_b;
   logic [3:0] d_b, q_b;
   logic       rco_b, e_b;

   // group c: two cascaded 4-bit stages
   logic [3:0] q_lo, q_hi;
   logic       rco_lo, rco_hi, e_lo, e_hi;

   int n_checks = 0;
   int n_errors = 0;

   always #5 fast_clk = ~fast_clk;

   logic_74xx161_param #(.WIDTH(4), .MAX(15), .CLR_SYNC(1'b0), .EDGE(1'b1), .UPDN(1'b0)) u_a (
      .FAST_CLK(fast_clk), .RST(rst_n), .I_CLK(iclk[0]), .I_CLR_N(clr_a_n), .I_LD_N(ld_a_n),
      .I_ENP(enp_a), .I_ENT(ent_a), .I_UP(1'b1), .I_D(d_a), .O_Q(q_a), .O_RCO(rco_a), .O_EDGE(e_a));

   logic_74xx161_param #(.WIDTH(4), .MAX(15), .CLR_SYNC(1'b0), .EDGE(1'b0), .UPDN(1'b0)) u_f (
      .FAST_CLK(fast_clk), .RST(rst_n), .I_CLK(iclk[0]), .I_CLR_N(clr_a_n), .I_LD_N(ld_a_n),
      .I_ENP(enp_a), .I_ENT(ent_a), .I_UP(1'b1), .I_D(d_a), .O_Q(q_f), .O_RCO(rco_f), .O_EDGE(e_f));

   logic_74xx161_param #(.WIDTH(4), .MAX(9), .CLR_SYNC(1'b1), .EDGE(1'b1), .UPDN(1'b1)) u_b (
      .FAST_CLK(fast_clk), .RST(rst_n), .I_CLK(iclk[1]), .I_CLR_N(clr_b_n), .I_LD_N(ld_b_n),
      .I_ENP(enp_b), .I_ENT(ent_b), .I_UP(up_b), .I_D(d_b), .O_Q(q_b), .O_RCO(rco_b), .O_EDGE(e_b));

   logic_74xx161_param #(.WIDTH(4), .MAX(15)) u_lo (
      .FAST_CLK(fast_clk), .RST(rst_n), .I_CLK(iclk[2]), .I_CLR_N(1'b1), .I_LD_N(1'b1),
      .I_ENP(1'b1), .I_ENT(1'b1), .I_UP(1'b1), .I_D(4'd0), .O_Q(q_lo), .O_RCO(rco_lo), .O_EDGE(e_lo));

   logic_74xx161_param #(.WIDTH(4), .MAX(15)) u_hi (
      .FAST_CLK(fast_clk), .RST(rst_n), .I_CLK(iclk[2]), .I_CLR_N(1'b1), .I_LD_N(1'b1),
      .I_ENP(1'b1), .I_ENT(rco_lo), .I_UP(1'b1), .I_D(4'd0), .O_Q(q_hi), .O_RCO(rco_hi), .O_EDGE(e_hi));

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge fast_clk);
      #1;
   endtask

   task automatic rise(input int k);
      iclk[k] = 1'b1;
      tick();
   endtask

   task automatic fall(input int k);
      iclk[k] = 1'b0;
      tick();
   endtask

   initial begin
      int exp;
      rst_n = 1'b0; iclk = 3'b000;
      clr_a_n = 1'b1; ld_a_n = 1'b1; enp_a = 1'b1; ent_a = 1'b1; d_a = 4'd0;
      clr_b_n = 1'b1; ld_b_n = 1'b1; enp_b = 1'b1; ent_b = 1'b1; up_b = 1'b1; d_b = 4'd0;
      tick(); tick();
      check("rst_q_a", q_a, 0);
      check("rst_q_b", q_b, 0);
      check("rst_edge_a", e_a, 0);
      check("rst_rco_a", rco_a, 0);
      rst_n = 1'b1;
      tick(); tick();
      check("rel_q_a", q_a, 0);
      check("rel_edge_a", e_a, 0);

      // 17 rising edges on a mod-16 counter; falling twin tracks one pulse later
      for (int i = 1; i <= 17; i++) begin
         exp = i % 16;
         rise(0);
         check("t1_q", q_a, exp);
         check("t1_edge_hi", e_a, 1);
         check("t1_rco", rco_a, (exp == 15) ? 1 : 0);
         check("t1_f_edge_lo", e_f, 0);
         fall(0);
         check("t1_edge_lo", e_a, 0);
         check("t1_q_hold", q_a, exp);
         check("t1_f_q", q_f, exp);
         check("t1_f_edge_hi", e_f, 1);
         check("t1_f_rco", rco_f, (exp == 15) ? 1 : 0);
      end

      // static I_CLK holds; async clear beats a simultaneous load
      rise(0); fall(0); rise(0); fall(0);
      tick(); tick(); tick();
      check("t3a_static_hold", q_a, 3);
      clr_a_n = 1'b0; ld_a_n = 1'b0; d_a = 4'd11;
      tick();
      check("t3a_async_clr", q_a, 0);
      clr_a_n = 1'b1; ld_a_n = 1'b1;
      tick();
      check("t3a_after_clr", q_a, 0);

      // load above MAX then climb through 15 and wrap
      ld_b_n = 1'b0; d_b = 4'd12;
      rise(1);
      check("t2_load", q_b, 12);
      check("t2_rco_12", rco_b, 0);
      ld_b_n = 1'b1;
      fall(1);
      for (int i = 1; i <= 5; i++) begin
         exp = (12 + i) % 16;
         rise(1);
         check("t2_q", q_b, exp);
         check("t2_rco", rco_b, 0);
         fall(1);
      end

      // count down from 1: 0, 9, 8
      up_b = 1'b0;
      #1;
      check("t4_rco_at1", rco_b, 0);
      rise(1);
      check("t4_q0", q_b, 0);
      check("t4_rco_q0", rco_b, 1);
      ent_b = 1'b0;
      #1;
      check("t4_rco_ent0", rco_b, 0);
      ent_b = 1'b1;
      #1;
      fall(1);
      rise(1);
      check("t4_q9", q_b, 9);
      check("t4_rco_q9", rco_b, 0);
      fall(1);
      rise(1);
      check("t4_q8", q_b, 8);
      fall(1);

      // edge-qualified clear: hold until the edge, then clear beats load
      clr_b_n = 1'b0; ld_b_n = 1'b0; d_b = 4'd5;
      tick(); tick();
      check("t3b_hold", q_b, 8);
      rise(1);
      check("t3b_sync_clr", q_b, 0);
      clr_b_n = 1'b1; ld_b_n = 1'b1;
      fall(1);

      // cascaded pair counts 0..255 and wraps
      for (int i = 1; i <= 256; i++) begin
         exp = i % 256;
         rise(2);
         check("t5_cnt", int'({q_hi, q_lo}), exp);
         check("t5_rco_hi", rco_hi, (exp == 255) ? 1 : 0);
         check("t5_edge", int'({e_hi, e_lo}), 3);
         fall(2);
      end

      // reset with I_CLK held at its active level must not count on release
      for (int i = 0; i < 6; i++) begin
         rise(0); fall(0);
      end
      rise(0);
      check("t6_pre", q_a, 7);
      rst_n = 1'b0;
      #2;
      check("t6_rst_imm", q_a, 0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      check("t6_no_count", q_a, 0);
      check("t6_no_edge", e_a, 0);
      fall(0);
      rise(0);
      check("t6_first", q_a, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/logic_74xx161_param.md
Name: logic_74xx161_param

Overview:
Parametrised, cascadable, presettable binary counter. It generalises the 74xx161/163/191 family: configurable width, terminal count, clear mode, active edge and optional up/down counting.
The logic-level counter clock I_CLK is edge-detected on the single system clock FAST_CLK, like the other logic IP models.
It replaces hand-wired chains of discrete counter and flip-flop models in the video timing and sound sections.

Parameters:
WIDTH, 4, counter width in bits (1..16).
MAX, 2**WIDTH-1, terminal count and wrap value; must be less than 2**WIDTH.
CLR_SYNC, 0, 0 = '161 style: clear acts on any FAST_CLK while asserted; 1 = '163 style: clear acts only on an active I_CLK edge.
EDGE, 1, 1 = count on I_CLK rising edge; 0 = count on I_CLK falling edge.
UPDN, 0, 0 = up-only and I_UP is ignored; 1 = I_UP selects the count direction.

Ports:
FAST_CLK  in  1  system clock; the only clock in the block.
RST  in  1  asynchronous active-low reset.
I_CLK  in  1  logic-level counter clock, synchronous to FAST_CLK, sampled and edge-detected.
I_CLR_N  in  1  active-low clear.
I_LD_N  in  1  active-low parallel load.
I_ENP  in  1  count enable P.
I_ENT  in  1  count enable T; also gates O_RCO.
I_UP  in  1  count direction, 1 = up; used only when UPDN=1.
I_D  in  WIDTH  parallel load data.
O_Q  out  WIDTH  counter value.
O_RCO  out  1  ripple carry out, combinational.
O_EDGE  out  1  one-FAST_CLK strobe marking a qualified active I_CLK edge.

Behaviour:
- Reset (RST=0, asynchronous):
  - O_Q = 0.
  - Edge register = EDGE, so no spurious edge is seen at reset release while I_CLK sits at its active level.
  - O_EDGE = 0.
- Edge detect:
  - clk_q <= I_CLK on every FAST_CLK.
  - edge = (clk_q != I_CLK) & (I_CLK == EDGE).
  - O_EDGE is the registered edge, high for exactly 1 FAST_CLK.
- Latency: O_Q changes on the FAST_CLK posedge that samples the active I_CLK transition, i.e. 1 FAST_CLK after I_CLK changes.
- Update priority, evaluated at each FAST_CLK posedge:
  1. Clear, CLR_SYNC=0: I_CLR_N=0 -> O_Q=0 on every FAST_CLK, no edge needed.
  2. Clear, CLR_SYNC=1: I_CLR_N=0 and edge -> O_Q=0.
  3. Else edge and I_LD_N=0 -> O_Q=I_D. The value is loaded as-is, even if it is above MAX.
  4. Else edge and I_ENP=1 and I_ENT=1 -> count.
  5. Else hold.
- Direction: dir_up = 1 when UPDN=0; dir_up = I_UP when UPDN=1.
- Count rules:
  - Up: O_Q==MAX -> 0; otherwise O_Q+1 mod 2**WIDTH. A value above MAX climbs to 2**WIDTH-1, then wraps to 0.
  - Down: O_Q==0 -> MAX; otherwise O_Q-1.
- O_RCO = I_ENT & (O_Q == (dir_up ? MAX : 0)). It is independent of I_ENP and of edges, so cascaded stages (RCO into next ENT, shared I_CLK) count synchronously.
- Simultaneous events:
  - Clear beats load, and load beats count.
  - I_UP changing in the same cycle as an edge: the value sampled at that FAST_CLK is used.
- No edge while I_CLK is static: with CLR_SYNC=0, only clear can alter O_Q.
- Reset mid-count: O_Q is forced to 0 immediately. Counting resumes at the first active edge after release; an I_CLK already at its active level at release does not count.

Decomposition:
- Shared include: local constants for the edge polarity values and the clear-mode values; these are reused by the other parametrised logic IP models.
- One natural sub-module: logic_edge_det (parameter EDGE; ports FAST_CLK, RST, I_CLK, O_EDGE). It holds the reset-to-EDGE register and is shared with future parametrised models (74xx109, 74xx174).
- The counter next-state logic stays in logic_74xx161_param.

Test Plan:
1. WIDTH=4, MAX=15, ENP=ENT=1, 17 rising I_CLK edges -> O_Q runs 1..15, 0, 1.
   - O_RCO is high only while O_Q=15.
   - O_EDGE gives 17 single-cycle pulses.
2. MAX=9, I_LD_N=0 with I_D=12 on one edge, then count -> O_Q 12, 13, 14, 15, 0, 1; O_RCO is never high at 12..15.
3. CLR_SYNC=0: I_CLR_N=0 mid-count with I_CLK static -> O_Q=0 on the next FAST_CLK. CLR_SYNC=1: O_Q holds until the next edge, then becomes 0. I_LD_N=0 at the same time -> clear wins.
4. UPDN=1, MAX=9, I_UP=0 from O_Q=1 over 3 edges -> O_Q 0, 9, 8; O_RCO is high while O_Q=0 and ENT=1.
5. Two WIDTH=4 instances cascaded (RCO into ENT of the upper stage), 256 edges -> {upper, lower} counts 0..255 and wraps to 0 with no glitch.
6. Assert RST with I_CLK high and O_Q=7, release with I_CLK still high -> O_Q=0 and no count. The first count follows the next low-to-high transition: O_Q=1.
